// File: rtl/ahb_apb_arbiter_pkg.sv
// Shared AHB definitions used by the two-master AHB-to-APB-bridge arbiter.
// Transfer-type and response encodings, plus master identifiers.
package ahb_apb_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic {
        MST0 = 1'b0,
        MST1 = 1'b1
    } mst_e;

    // NONSEQ and SEQ both carry htrans[1]=1
    function automatic logic is_req(input logic hsel, input logic [1:0] htrans);
        return hsel & htrans[1];
    endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Next-owner decision for the two-master arbiter, including the round-robin
// pointer that remembers who owned the last accepted transfer.
module ahb_arb_pick
    import ahb_apb_arbiter_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic grant,
    input  logic req0,
    input  logic req1,
    input  logic owner_lock,
    input  logic parked,
    input  logic s_hready,
    output logic next_grant,
    output logic owner_go,
    output logic yield_owner
);

    logic last_owner;
    logic owner_req;
    logic other_req;
    logic winner;
    logic contest;

    // A contest is a simultaneous request arriving while the owner sat idle
    // and unlocked; a losing owner is held off so the winner goes first.
    always_comb begin
        owner_req   = grant ? req1 : req0;
        other_req   = grant ? req0 : req1;
        winner      = (RR_EN != 0) ? ~last_owner : MST0;
        contest     = req0 & req1 & parked & ~owner_lock;
        yield_owner = contest & (winner != grant);
        owner_go    = owner_req & ~yield_owner;
        next_grant  = grant;
        if (s_hready && !owner_go && !owner_lock && other_req)
            next_grant = ~grant;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            last_owner <= MST0;
        else if (s_hready && owner_go)
            last_owner <= grant;
    end

endmodule

// File: rtl/ahb_apb_arbiter.sv
// Two-master AHB arbiter in front of a single APB bridge slave port:
// zero-latency address muxing, data-phase tracking and response routing.
module ahb_apb_arbiter
    import ahb_apb_arbiter_pkg::*;
#(
    parameter int RR_EN  = 1,
    parameter int ADDR_W = 36
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              m0_hsel,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [2:0]        m0_hburst,
    input  logic              m0_hmastlock,
    input  logic [63:0]       m0_hwdata,
    output logic              m0_hready,
    output logic              m0_hresp,
    output logic [63:0]       m0_hrdata,
    input  logic              m1_hsel,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic [1:0]        m1_htrans,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [2:0]        m1_hburst,
    input  logic              m1_hmastlock,
    input  logic [63:0]       m1_hwdata,
    output logic              m1_hready,
    output logic              m1_hresp,
    output logic [63:0]       m1_hrdata,
    output logic              s_hsel,
    output logic [ADDR_W-1:0] s_haddr,
    output logic [1:0]        s_htrans,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [2:0]        s_hburst,
    output logic              s_hmastlock,
    output logic [63:0]       s_hwdata,
    input  logic              s_hready,
    input  logic              s_hresp,
    input  logic [63:0]       s_hrdata,
    output logic              grant
);

    logic req0, req1;
    logic owner_lock;
    logic next_grant, owner_go, yield_owner;
    logic dp_valid, dp_owner;
    logic go;

    assign req0       = is_req(m0_hsel, m0_htrans);
    assign req1       = is_req(m1_hsel, m1_htrans);
    assign owner_lock = grant ? m1_hmastlock : m0_hmastlock;

    ahb_arb_pick #(.RR_EN(RR_EN)) u_pick (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .grant       (grant),
        .req0        (req0),
        .req1        (req1),
        .owner_lock  (owner_lock),
        .parked      (~dp_valid),
        .s_hready    (s_hready),
        .next_grant  (next_grant),
        .owner_go    (owner_go),
        .yield_owner (yield_owner)
    );

    // Nothing may reach the slave while reset is held
    assign go = owner_go & HRESETn;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant    <= MST0;
            dp_valid <= 1'b0;
            dp_owner <= MST0;
        end else if (s_hready) begin
            grant    <= next_grant;
            dp_valid <= go;
            dp_owner <= grant;
        end
    end

    always_comb begin
        s_hsel      = go;
        s_htrans    = HTRANS_IDLE;
        s_haddr     = grant ? m1_haddr     : m0_haddr;
        s_hwrite    = grant ? m1_hwrite    : m0_hwrite;
        s_hsize     = grant ? m1_hsize     : m0_hsize;
        s_hburst    = grant ? m1_hburst    : m0_hburst;
        s_hmastlock = grant ? m1_hmastlock : m0_hmastlock;
        if (go)
            s_htrans = grant ? m1_htrans : m0_htrans;
        if (dp_valid)
            s_hwdata = dp_owner ? m1_hwdata : m0_hwdata;
        else
            s_hwdata = grant ? m1_hwdata : m0_hwdata;
    end

    // Data-phase owner sees the slave's ready first; a waiting requester is stalled
    always_comb begin
        m0_hready = 1'b1;
        m1_hready = 1'b1;
        if (HRESETn) begin
            if (dp_valid && dp_owner == MST0)         m0_hready = s_hready;
            else if (grant == MST0 && !yield_owner)   m0_hready = s_hready;
            else if (req0)                            m0_hready = 1'b0;
            if (dp_valid && dp_owner == MST1)         m1_hready = s_hready;
            else if (grant == MST1 && !yield_owner)   m1_hready = s_hready;
            else if (req1)                            m1_hready = 1'b0;
        end
    end

    assign m0_hresp  = (dp_valid && dp_owner == MST0) ? s_hresp : HRESP_OKAY;
    assign m1_hresp  = (dp_valid && dp_owner == MST1) ? s_hresp : HRESP_OKAY;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

endmodule

// File: tb/tb_ahb_apb_arbiter.sv
// Scoreboard bench for ahb_apb_arbiter: a round-robin instance and a
// fixed-priority instance share stimulus; a monitor checks expectations per cycle.
module tb_ahb_apb_arbiter;

    localparam int AW = 36;

    localparam int S_GRANT    = 0;
    localparam int S_GRANT_FP = 1;
    localparam int S_HSEL     = 2;
    localparam int S_HTRANS   = 3;
    localparam int S_HADDR    = 4;
    localparam int S_HWDATA   = 5;
    localparam int S_M0RDY    = 6;
    localparam int S_M1RDY    = 7;
    localparam int S_M0RESP   = 8;
    localparam int S_M1RESP   = 9;
    localparam int S_M0RDATA  = 10;
    localparam int S_M1RDATA  = 11;

    typedef struct {
        int          due;
        int          sel;
        logic [63:0] val;
        string       name;
    } exp_t;

    logic HCLK = 1'b0;
    logic HRESETn;
    logic m0_hsel, m1_hsel, m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock;
    logic [AW-1:0] m0_haddr, m1_haddr;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
    logic [63:0] m0_hwdata, m1_hwdata;
    logic        s_hready, s_hresp;
    logic [63:0] s_hrdata;

    logic m0_hready, m1_hready, m0_hresp, m1_hresp, grant;
    logic [63:0] m0_hrdata, m1_hrdata, s_hwdata;
    logic s_hsel, s_hwrite, s_hmastlock;
    logic [AW-1:0] s_haddr;
    logic [1:0] s_htrans;
    logic [2:0] s_hsize, s_hburst;

    logic fp_m0_hready, fp_m1_hready, fp_m0_hresp, fp_m1_hresp, fp_grant;
    logic [63:0] fp_m0_hrdata, fp_m1_hrdata, fp_s_hwdata;
    logic fp_s_hsel, fp_s_hwrite, fp_s_hmastlock;
    logic [AW-1:0] fp_s_haddr;
    logic [1:0] fp_s_htrans;
    logic [2:0] fp_s_hsize, fp_s_hburst;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic done_req = 1'b0;
    logic done_ack = 1'b0;
    exp_t sb[$];

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    ahb_apb_arbiter #(.RR_EN(1), .ADDR_W(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_hsel(m0_hsel), .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
        .m0_hsize(m0_hsize), .m0_hburst(m0_hburst), .m0_hmastlock(m0_hmastlock), .m0_hwdata(m0_hwdata),
        .m0_hready(m0_hready), .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
        .m1_hsel(m1_hsel), .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
        .m1_hsize(m1_hsize), .m1_hburst(m1_hburst), .m1_hmastlock(m1_hmastlock), .m1_hwdata(m1_hwdata),
        .m1_hready(m1_hready), .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata),
        .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata), .grant(grant)
    );

    ahb_apb_arbiter #(.RR_EN(0), .ADDR_W(AW)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_hsel(m0_hsel), .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
        .m0_hsize(m0_hsize), .m0_hburst(m0_hburst), .m0_hmastlock(m0_hmastlock), .m0_hwdata(m0_hwdata),
        .m0_hready(fp_m0_hready), .m0_hresp(fp_m0_hresp), .m0_hrdata(fp_m0_hrdata),
        .m1_hsel(m1_hsel), .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
        .m1_hsize(m1_hsize), .m1_hburst(m1_hburst), .m1_hmastlock(m1_hmastlock), .m1_hwdata(m1_hwdata),
        .m1_hready(fp_m1_hready), .m1_hresp(fp_m1_hresp), .m1_hrdata(fp_m1_hrdata),
        .s_hsel(fp_s_hsel), .s_haddr(fp_s_haddr), .s_htrans(fp_s_htrans), .s_hwrite(fp_s_hwrite),
        .s_hsize(fp_s_hsize), .s_hburst(fp_s_hburst), .s_hmastlock(fp_s_hmastlock), .s_hwdata(fp_s_hwdata),
        .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata), .grant(fp_grant)
    );

    function automatic logic [63:0] sample(input int sel);
        case (sel)
            S_GRANT:    return {63'd0, grant};
            S_GRANT_FP: return {63'd0, fp_grant};
            S_HSEL:     return {63'd0, s_hsel};
            S_HTRANS:   return {62'd0, s_htrans};
            S_HADDR:    return {28'd0, s_haddr};
            S_HWDATA:   return s_hwdata;
            S_M0RDY:    return {63'd0, m0_hready};
            S_M1RDY:    return {63'd0, m1_hready};
            S_M0RESP:   return {63'd0, m0_hresp};
            S_M1RESP:   return {63'd0, m1_hresp};
            S_M0RDATA:  return m0_hrdata;
            S_M1RDATA:  return m1_hrdata;
            default:    return 64'hx;
        endcase
    endfunction

    // Monitor: pop every expectation due in this cycle and compare mid-cycle
    always @(negedge HCLK) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            logic [63:0] act;
            e = sb.pop_front();
            checks++;
            act = sample(e.sel);
            if (e.due < cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.name, e.due, cyc);
            end else if (act !== e.val) begin
                failures++;
                $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", e.name, cyc, act, e.val);
            end
        end
        if (done_req && !done_ack) begin
            checks++;
            if (sb.size() != 0) begin
                failures++;
                $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
            end
            done_ack <= 1'b1;
        end
    end

    task automatic chk(input int sel, input logic [63:0] val, input string nm);
        sb.push_back('{cyc, sel, val, nm});
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv(input int m, input logic sel, input logic [1:0] tr,
                       input logic [AW-1:0] a, input logic wr, input logic lk);
        if (m == 0) begin
            m0_hsel = sel; m0_htrans = tr; m0_haddr = a; m0_hwrite = wr; m0_hmastlock = lk;
        end else begin
            m1_hsel = sel; m1_htrans = tr; m1_haddr = a; m1_hwrite = wr; m1_hmastlock = lk;
        end
    endtask

    task automatic idle_all();
        drv(0, 1'b0, 2'b00, '0, 1'b0, 1'b0);
        drv(1, 1'b0, 2'b00, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick();
        HRESETn = 1'b0;
        idle_all();
        s_hready = 1'b1;
        s_hresp  = 1'b0;
        tick();
        HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn = 1'b0;
        idle_all();
        m0_hsize = 3'b011; m1_hsize = 3'b011; m0_hburst = 3'b000; m1_hburst = 3'b000;
        m0_hwdata = '0; m1_hwdata = '0;
        s_hready = 1'b0; s_hresp = 1'b1; s_hrdata = '0;

        // Reset: requests and a stalled/erroring slave must not leak through
        tick();
        drv(0, 1'b1, 2'b10, 36'h0_4000_0000, 1'b0, 1'b0);
        tick();
        chk(S_GRANT, 0, "rst_grant");   chk(S_M0RDY, 1, "rst_m0_hready");
        chk(S_M1RDY, 1, "rst_m1_hready"); chk(S_HSEL, 0, "rst_s_hsel");
        chk(S_HTRANS, 0, "rst_s_htrans"); chk(S_M0RESP, 0, "rst_m0_hresp");
        tick();
        HRESETn = 1'b1; idle_all(); s_hready = 1'b1; s_hresp = 1'b0;

        // m0 NONSEQ read with one wait state
        tick();
        drv(0, 1'b1, 2'b10, 36'h0_4000_0000, 1'b0, 1'b0);
        chk(S_HADDR, 64'h0_4000_0000, "a_s_haddr"); chk(S_HSEL, 1, "a_s_hsel");
        chk(S_HTRANS, 2, "a_s_htrans"); chk(S_M0RDY, 1, "a_m0_hready");
        tick();
        idle_all(); s_hready = 1'b0; s_hrdata = 64'hDEAD_BEEF_0123_4567;
        chk(S_M0RDY, 0, "a_m0_wait"); chk(S_M1RDY, 1, "a_m1_hready_idle");
        tick();
        s_hready = 1'b1;
        chk(S_M0RDY, 1, "a_m0_done"); chk(S_M0RDATA, 64'hDEAD_BEEF_0123_4567, "a_m0_hrdata");
        chk(S_M0RESP, 0, "a_m0_hresp");

        // m1 handover from idle m0
        tick();
        drv(1, 1'b1, 2'b10, 36'h1_0000_0010, 1'b1, 1'b0);
        chk(S_M1RDY, 0, "b_m1_stall"); chk(S_GRANT, 0, "b_grant_before"); chk(S_HSEL, 0, "b_s_hsel");
        tick();
        chk(S_GRANT, 1, "b_grant_after"); chk(S_HADDR, 64'h1_0000_0010, "b_s_haddr");
        chk(S_M1RDY, 1, "b_m1_hready"); chk(S_HSEL, 1, "b_s_hsel_m1");
        tick();
        idle_all(); m1_hwdata = 64'hAAAA_5555_0000_1111; m0_hwdata = 64'h0;
        chk(S_HWDATA, 64'hAAAA_5555_0000_1111, "b_s_hwdata");

        // m0 write data phase with 3 wait states while m1 waits for the bus
        tick();
        drv(0, 1'b1, 2'b10, 36'h200, 1'b1, 1'b0);
        chk(S_M0RDY, 0, "c_m0_stall"); chk(S_GRANT, 1, "c_grant_m1");
        tick();
        drv(1, 1'b1, 2'b10, 36'h300, 1'b0, 1'b0);
        chk(S_GRANT, 0, "c_grant_m0"); chk(S_HADDR, 64'h200, "c_s_haddr");
        chk(S_M0RDY, 1, "c_m0_accept"); chk(S_M1RDY, 0, "c_m1_wait");
        tick();
        drv(0, 1'b0, 2'b00, '0, 1'b0, 1'b0);
        m0_hwdata = 64'h0BAD_CAFE_F00D_0001; m1_hwdata = 64'h9999_8888_7777_6666;
        s_hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk(S_HWDATA, 64'h0BAD_CAFE_F00D_0001, "c_s_hwdata_wait");
            chk(S_M0RDY, 0, "c_m0_hready_wait"); chk(S_M1RDY, 0, "c_m1_hready_wait");
            chk(S_GRANT, 0, "c_grant_frozen");
            tick();
        end
        s_hready = 1'b1;
        chk(S_M0RDY, 1, "c_m0_done"); chk(S_HWDATA, 64'h0BAD_CAFE_F00D_0001, "c_s_hwdata_done");
        chk(S_M1RDY, 0, "c_m1_still_wait");
        tick();
        chk(S_GRANT, 1, "c_grant_flip"); chk(S_HADDR, 64'h300, "c_s_haddr_m1");
        chk(S_M1RDY, 1, "c_m1_accept"); chk(S_GRANT_FP, 1, "c_fp_grant_flip");

        // Two-cycle ERROR on m1's data phase
        tick();
        idle_all(); s_hready = 1'b0; s_hresp = 1'b1;
        chk(S_M1RESP, 1, "d_err1_m1_hresp"); chk(S_M1RDY, 0, "d_err1_m1_hready");
        chk(S_M0RESP, 0, "d_err1_m0_hresp");
        tick();
        s_hready = 1'b1;
        chk(S_M1RESP, 1, "d_err2_m1_hresp"); chk(S_M1RDY, 1, "d_err2_m1_hready");
        chk(S_M0RESP, 0, "d_err2_m0_hresp");
        tick();
        s_hresp = 1'b0;
        chk(S_M1RESP, 0, "d_after_m1_hresp");

        // Locked m0 sequence with IDLE gaps; m1 requests throughout
        do_reset();
        chk(S_GRANT, 0, "e_post_rst_grant");
        tick();
        drv(1, 1'b1, 2'b10, 36'h500, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drv(0, 1'b1, 2'b10, 36'h400 + AW'(4 * k), 1'b0, 1'b1);
            chk(S_GRANT, 0, "e_lock_grant"); chk(S_HADDR, 64'h400 + 64'(4 * k), "e_lock_haddr");
            chk(S_M1RDY, 0, "e_lock_m1_wait");
            tick();
            drv(0, 1'b1, 2'b00, '0, 1'b0, (k < 3) ? 1'b1 : 1'b0);
            chk(S_GRANT, 0, "e_idle_grant"); chk(S_HSEL, 0, "e_idle_s_hsel");
            chk(S_M1RDY, 0, "e_idle_m1_wait");
            tick();
        end
        chk(S_GRANT, 1, "e_unlock_grant"); chk(S_HADDR, 64'h500, "e_unlock_haddr");
        chk(S_M1RDY, 1, "e_unlock_m1_hready");

        // Simultaneous requests after an m0 transfer: RR picks m1, fixed picks m0
        do_reset();
        tick();
        drv(0, 1'b1, 2'b10, 36'h600, 1'b0, 1'b0);
        tick();
        idle_all();
        tick();
        drv(0, 1'b1, 2'b10, 36'h610, 1'b0, 1'b0);
        drv(1, 1'b1, 2'b10, 36'h700, 1'b0, 1'b0);
        chk(S_GRANT, 0, "f_grant_contest"); chk(S_HSEL, 0, "f_s_hsel_yield");
        chk(S_M0RDY, 0, "f_m0_yield"); chk(S_M1RDY, 0, "f_m1_wait");
        tick();
        chk(S_GRANT, 1, "f_rr_grant_m1"); chk(S_HADDR, 64'h700, "f_rr_haddr");
        chk(S_M1RDY, 1, "f_rr_m1_hready"); chk(S_GRANT_FP, 0, "f_fp_grant_m0");
        tick();
        idle_all();
        tick();

        done_req = 1'b1;
        for (int i = 0; i < 10 && !done_ack; i++) @(posedge HCLK);
        if (!done_ack) begin
            $display("FAIL monitor_drain: got no ack, expected ack within 10 cycles");
            $fatal(1, "monitor did not respond");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
